// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - radix-2 iterative 16-bit multiplier/divider (optional signed mode: MUL_DIV_SIGNED_EN)
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MUL_DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic             load_lo,
    output logic             load_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div0
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;
    logic [WIDTH-1:0]   hi_q, lo_q, b_q;
    logic               busy_q, done_q, div0_q;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;
`ifdef MUL_DIV_SIGNED_EN
    logic               neg_lo_q, neg_hi_q;
    logic               a_neg, b_neg;
`endif

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     r_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               is_div0;
    logic [2*WIDTH-1:0] fin_d;

    // hi/lo double as {partial product, multiplier} or {remainder, quotient}
    always_comb begin
`ifdef MUL_DIV_SIGNED_EN
        a_neg = signed_op & a[WIDTH-1];
        b_neg = signed_op & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
`else
        a_mag = a;
        b_mag = b;
`endif
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        r_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge  = (r_shift >= {1'b0, b_q});
        div_sub = r_shift[WIDTH-1:0] - b_q;
        if (op_q) begin
            hi_d = div_ge ? div_sub : r_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        is_div0 = op_q && (b_q == '0);
        fin_d   = {hi_d, lo_d};
`ifdef MUL_DIV_SIGNED_EN
        // sign fix-up on the final iteration keeps latency identical to unsigned
        if (op_q) begin
            fin_d[WIDTH-1:0]       = (neg_lo_q && !is_div0) ? -lo_d : lo_d;
            fin_d[2*WIDTH-1:WIDTH] = neg_hi_q ? -hi_d : hi_d;
        end else if (neg_lo_q) begin
            fin_d = -{hi_d, lo_d};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
`ifdef MUL_DIV_SIGNED_EN
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        hi_q    <= '0;
                        lo_q    <= a_mag;
                        b_q     <= b_mag;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        div0_q  <= 1'b0;
                        state_q <= S_RUN;
`ifdef MUL_DIV_SIGNED_EN
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
`endif
                    end
                end
                S_RUN: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        res_lo_q <= fin_d[WIDTH-1:0];
                        res_hi_q <= fin_d[2*WIDTH-1:WIDTH];
                        div0_q   <= is_div0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign load_lo   = done_q;
    assign load_hi   = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign div0      = div0_q;

endmodule
